// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths and result-source encoding for the writeback arbiter
package wb_arbiter_pkg;
  localparam int WORD = 32;
  localparam int REG_LOG = 5;
  typedef enum logic [1:0] {SRC_ALU = 2'd0, SRC_LSU = 2'd1, SRC_MDU = 2'd2} src_e;
endpackage

// File: rtl/wb_rr_pick.sv
// wb_rr_pick: 2-way round-robin picker, req[0]=LSU, req[1]=MDU, ptr=1 favours MDU
module wb_rr_pick (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant,
  output logic       ptr_next
);
  always_comb begin
    grant = &req ? (ptr ? 2'b10 : 2'b01) : req;
    ptr_next = &req ? ~ptr : ptr;
  end
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU-priority writeback arbiter with LSU/MDU round-robin; WB_STALL_CNT_EN adds wb_stall_cnt
module wb_arbiter
  import wb_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               alu_valid,
  input  logic [REG_LOG-1:0] alu_rd,
  input  logic [WORD-1:0]    alu_data,
  input  logic               lsu_valid,
  input  logic [REG_LOG-1:0] lsu_rd,
  input  logic [WORD-1:0]    lsu_data,
  output logic               lsu_ready,
  input  logic               mdu_valid,
  input  logic [REG_LOG-1:0] mdu_rd,
  input  logic [WORD-1:0]    mdu_data,
  output logic               mdu_ready,
  output logic               RFWrite,
  output logic [REG_LOG-1:0] rd,
  output logic [WORD-1:0]    rd_WriteData,
  output logic               wb_idle
`ifdef WB_STALL_CNT_EN
  ,
  output logic [WORD-1:0]    wb_stall_cnt
`endif
);
  logic               ptr_q, ptr_d, rr_ptr_next, rr_en, acc;
  logic [1:0]         grant;
  src_e               acc_src;
  logic [REG_LOG-1:0] acc_rd, rd_q, rd_d;
  logic [WORD-1:0]    acc_data, data_q, data_d;
  logic               rf_write_q, rf_write_d;
  wb_rr_pick u_pick (
    .req      ({mdu_valid, lsu_valid}),
    .ptr      (ptr_q),
    .grant    (grant),
    .ptr_next (rr_ptr_next)
  );
  // The pointer only advances in ALU-free cycles, so a contended grant that is vetoed by the ALU does not count.
  always_comb begin
    rr_en = !rst && !alu_valid;
    lsu_ready = rr_en && grant[0];
    mdu_ready = rr_en && grant[1];
    acc = !rst && (alu_valid || lsu_ready || mdu_ready);
    acc_src = alu_valid ? SRC_ALU : (grant[1] ? SRC_MDU : SRC_LSU);
    acc_rd = acc_src == SRC_ALU ? alu_rd : (acc_src == SRC_MDU ? mdu_rd : lsu_rd);
    acc_data = acc_src == SRC_ALU ? alu_data : (acc_src == SRC_MDU ? mdu_data : lsu_data);
    ptr_d = rr_en ? rr_ptr_next : ptr_q;
    rf_write_d = acc && |acc_rd;
    rd_d = acc ? acc_rd : rd_q;
    data_d = acc ? acc_data : data_q;
    wb_idle = rst || !(alu_valid || lsu_valid || mdu_valid || rf_write_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
      rf_write_q <= 1'b0;
      rd_q <= '0;
      data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rf_write_q <= rf_write_d;
      rd_q <= rd_d;
      data_q <= data_d;
    end
  end
  assign RFWrite = rf_write_q;
  assign rd = rd_q;
  assign rd_WriteData = data_q;
`ifdef WB_STALL_CNT_EN
  logic [WORD-1:0] stall_cnt_q, stall_cnt_d;
  always_comb begin
    stall_cnt_d = ((lsu_valid && !lsu_ready) || (mdu_valid && !mdu_ready)) && !(&stall_cnt_q)
                  ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else stall_cnt_q <= stall_cnt_d;
  end
  assign wb_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed scenarios plus randomized traffic against a source-level reference model
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic               rst = 1'b1;
  logic               alu_valid = 1'b0, lsu_valid = 1'b0, mdu_valid = 1'b0;
  logic [REG_LOG-1:0] alu_rd = '0, lsu_rd = '0, mdu_rd = '0;
  logic [WORD-1:0]    alu_data = '0, lsu_data = '0, mdu_data = '0;
  logic               lsu_ready, mdu_ready, RFWrite, wb_idle;
  logic [REG_LOG-1:0] rd;
  logic [WORD-1:0]    rd_WriteData;
`ifdef WB_STALL_CNT_EN
  logic [WORD-1:0]    wb_stall_cnt;
`endif
  int total = 0, bad = 0;
  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
    .RFWrite(RFWrite), .rd(rd), .rd_WriteData(rd_WriteData), .wb_idle(wb_idle)
`ifdef WB_STALL_CNT_EN
    , .wb_stall_cnt(wb_stall_cnt)
`endif
  );
  // Reference model: who wins this cycle, what the write port shows next cycle.
  int                 m_win;
  bit                 m_mdu_next;
  logic               m_rf, e_lsu, e_mdu, e_idle;
  logic [REG_LOG-1:0] m_rd;
  logic [WORD-1:0]    m_data, m_cnt;
  task automatic model_tick();
    e_idle = rst || !(alu_valid || lsu_valid || mdu_valid || m_rf);
    if (rst) begin
      m_win = 0; m_mdu_next = 0; m_rf = 0; m_rd = '0; m_data = '0; m_cnt = '0;
      e_lsu = 0; e_mdu = 0;
      return;
    end
    if (alu_valid) m_win = 1;
    else if (lsu_valid && mdu_valid) begin
      m_win = m_mdu_next ? 3 : 2;
      m_mdu_next = !m_mdu_next;
    end else m_win = lsu_valid ? 2 : (mdu_valid ? 3 : 0);
    e_lsu = m_win == 2;
    e_mdu = m_win == 3;
    if (((lsu_valid && m_win != 2) || (mdu_valid && m_win != 3)) && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    if (m_win == 1) begin m_rd = alu_rd; m_data = alu_data; end
    if (m_win == 2) begin m_rd = lsu_rd; m_data = lsu_data; end
    if (m_win == 3) begin m_rd = mdu_rd; m_data = mdu_data; end
    m_rf = m_win != 0 && m_rd != 0;
  endtask
  task automatic clear_inputs();
    alu_valid = 0; lsu_valid = 0; mdu_valid = 0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1; clear_inputs();
    #1 model_tick();
    @(posedge clk); #1;
    rst = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 7; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    rst = 1; lsu_valid = 1; lsu_rd = 2; mdu_valid = 1; mdu_rd = 3;
    #1;
    total++; if (lsu_ready !== 1'b0) begin bad++; $display("FAIL reset_lsu_ready: got %b exp 0", lsu_ready); end
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL reset_mdu_ready: got %b exp 0", mdu_ready); end
    total++; if (wb_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b exp 1", wb_idle); end
    @(posedge clk); #1;
    total++; if ({RFWrite, rd, rd_WriteData} !== '0) begin bad++; $display("FAIL reset_regs: got %b/%0d/%h exp 0/0/0", RFWrite, rd, rd_WriteData); end
    rst = 0; clear_inputs();
    @(negedge clk); #1;
    total++; if (wb_idle !== 1'b1) begin bad++; $display("FAIL idle_after_reset: got %b exp 1", wb_idle); end
  endtask
  task automatic test_alu_only();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
    @(posedge clk); #1;
    total++; if ({RFWrite, rd, rd_WriteData} !== {1'b1, 5'd5, 32'h1234_5678}) begin bad++; $display("FAIL alu_write: got %b/%0d/%h exp 1/5/12345678", RFWrite, rd, rd_WriteData); end
    @(negedge clk);
    alu_valid = 0; #1;
    total++; if (wb_idle !== 1'b0) begin bad++; $display("FAIL idle_while_writing: got %b exp 0", wb_idle); end
    @(posedge clk); #1;
    total++; if ({RFWrite, rd, rd_WriteData} !== {1'b0, 5'd5, 32'h1234_5678}) begin bad++; $display("FAIL alu_hold: got %b/%0d/%h exp 0/5/12345678", RFWrite, rd, rd_WriteData); end
  endtask
  task automatic test_all_three();
    logic [REG_LOG-1:0] exp_rd [3] = '{5'd3, 5'd4, 5'd6};
    logic [WORD-1:0]    exp_dt [3] = '{32'hA, 32'hB, 32'hC};
    logic [1:0]         exp_rdy [3] = '{2'b00, 2'b01, 2'b10};
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hB;
    mdu_valid = 1; mdu_rd = 6; mdu_data = 32'hC;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if ({mdu_ready, lsu_ready} !== exp_rdy[c]) begin bad++; $display("FAIL all3_ready_c%0d: got %b exp %b", c, {mdu_ready, lsu_ready}, exp_rdy[c]); end
      @(posedge clk); #1;
      total++; if ({RFWrite, rd, rd_WriteData} !== {1'b1, exp_rd[c], exp_dt[c]}) begin bad++; $display("FAIL all3_write_c%0d: got %b/%0d/%h exp 1/%0d/%h", c, RFWrite, rd, rd_WriteData, exp_rd[c], exp_dt[c]); end
      @(negedge clk);
      if (c == 0) alu_valid = 0;
      if (c == 1) lsu_valid = 0;
      if (c == 2) mdu_valid = 0;
    end
  endtask
  task automatic test_alternate();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      lsu_valid = 1; lsu_rd = 5'(8 + k); lsu_data = 32'h100 + k;
      mdu_valid = 1; mdu_rd = 5'(16 + k); mdu_data = 32'h200 + k;
      #1;
      total++; if ({mdu_ready, lsu_ready} !== (k % 2 == 0 ? 2'b01 : 2'b10)) begin bad++; $display("FAIL alt_grant_%0d: got %b exp %b", k, {mdu_ready, lsu_ready}, (k % 2 == 0 ? 2'b01 : 2'b10)); end
      @(posedge clk); #1;
      total++; if (rd !== (k % 2 == 0 ? 5'(8 + k) : 5'(16 + k))) begin bad++; $display("FAIL alt_rd_%0d: got %0d exp %0d", k, rd, (k % 2 == 0 ? 8 + k : 16 + k)); end
    end
    clear_inputs();
  endtask
  task automatic test_rd_zero();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    total++; if (RFWrite !== 1'b0) begin bad++; $display("FAIL rd_zero_write: got %b exp 0", RFWrite); end
    clear_inputs();
  endtask
  task automatic test_reset_in_flight();
    do_reset();
    @(negedge clk);
    mdu_valid = 1; mdu_rd = 9; mdu_data = 32'h55; rst = 1;
    #1;
    total++; if (mdu_ready !== 1'b0) begin bad++; $display("FAIL flight_ready_in_reset: got %b exp 0", mdu_ready); end
    @(posedge clk); #1;
    total++; if (RFWrite !== 1'b0) begin bad++; $display("FAIL flight_write_after_reset: got %b exp 0", RFWrite); end
    rst = 0;
    @(negedge clk); #1;
    total++; if (mdu_ready !== 1'b1) begin bad++; $display("FAIL flight_represent_ready: got %b exp 1", mdu_ready); end
    @(posedge clk); #1;
    total++; if ({RFWrite, rd} !== {1'b1, 5'd9}) begin bad++; $display("FAIL flight_write_once: got %b/%0d exp 1/9", RFWrite, rd); end
    @(negedge clk);
    mdu_valid = 0;
    @(posedge clk); #1;
    total++; if (RFWrite !== 1'b0) begin bad++; $display("FAIL flight_single_write: got %b exp 0", RFWrite); end
  endtask
`ifdef WB_STALL_CNT_EN
  task automatic test_stall_cnt();
    do_reset();
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 12; alu_valid = 1;
    for (int c = 0; c < 3; c++) begin
      alu_rd = 5'(c + 1); alu_data = c;
      @(negedge clk);
    end
    alu_valid = 0;
    @(posedge clk); #1;
    lsu_valid = 0;
    total++; if (wb_stall_cnt !== 32'd3) begin bad++; $display("FAIL stall_cnt: got %0d exp 3", wb_stall_cnt); end
  endtask
`endif
  task automatic test_random(int n);
    int win = 0;
    do_reset();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = $urandom_range(0, 49) == 0;
      alu_valid = $urandom_range(0, 2) == 0; alu_rd = 5'($urandom); alu_data = $urandom;
      if (win == 2 || !lsu_valid) begin lsu_valid = 1'($urandom); lsu_rd = 5'($urandom); lsu_data = $urandom; end
      if (win == 3 || !mdu_valid) begin mdu_valid = 1'($urandom); mdu_rd = 5'($urandom); mdu_data = $urandom; end
      #1 model_tick();
      win = m_win;
      total++; if ({mdu_ready, lsu_ready} !== {e_mdu, e_lsu}) begin bad++; $display("FAIL rand_ready_%0d: got %b exp %b", i, {mdu_ready, lsu_ready}, {e_mdu, e_lsu}); end
      total++; if (wb_idle !== e_idle) begin bad++; $display("FAIL rand_idle_%0d: got %b exp %b", i, wb_idle, e_idle); end
      @(posedge clk); #1;
      total++; if ({RFWrite, rd, rd_WriteData} !== {m_rf, m_rd, m_data}) begin bad++; $display("FAIL rand_write_%0d: got %b/%0d/%h exp %b/%0d/%h", i, RFWrite, rd, rd_WriteData, m_rf, m_rd, m_data); end
`ifdef WB_STALL_CNT_EN
      total++; if (wb_stall_cnt !== m_cnt) begin bad++; $display("FAIL rand_stall_%0d: got %0d exp %0d", i, wb_stall_cnt, m_cnt); end
`endif
    end
    rst = 0; clear_inputs();
  endtask
  initial begin
    test_reset();
    test_alu_only();
    test_all_three();
    test_alternate();
    test_rd_zero();
    test_reset_in_flight();
`ifdef WB_STALL_CNT_EN
    test_stall_cnt();
`endif
    test_random(2000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
